// File: rtl/banked_multiport_memory_pkg.sv
// Shared helpers for the banked multiport memory: bank/row address split.
package banked_multiport_memory_pkg;

    // Default configuration: 4-bit word address, 2 banks.
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_BANKS  = 2;

    // Bank-select bits; 0 when there is a single bank.
    localparam int BANK_W = (DEF_NUM_BANKS > 1) ? $clog2(DEF_NUM_BANKS) : 0;
    // Row bits left after the bank-select bits are removed.
    localparam int ROW_W  = DEF_ADDR_WIDTH - BANK_W;

    // Number of bank-select bits for a given bank count.
    function automatic int unsigned bank_w_of(input int unsigned num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 0;
    endfunction

    // Low address bits select the bank; everything maps to bank 0 when bank_w is 0.
    function automatic int unsigned bank_of(input logic [31:0] addr, input int unsigned bank_w);
        logic [31:0] mask;
        mask = (bank_w == 0) ? 32'd0 : ((32'd1 << bank_w) - 32'd1);
        return addr & mask;
    endfunction

    // Remaining upper address bits select the row inside the bank.
    function automatic int unsigned row_of(input logic [31:0] addr, input int unsigned bank_w);
        return addr >> bank_w;
    endfunction

endpackage

// File: rtl/banked_multiport_memory_rr_arbiter.sv
// Round-robin arbiter: highest priority goes to the port after the last grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    // Search from the pointer upward, wrapping; grants are held low in reset.
    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N) idx = idx - N;
            if (!found && rst_n && req[idx]) begin
                grant[idx] = 1'b1;
                ptr_next   = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
                found      = 1'b1;
            end
        end
    end

    // Pointer only moves when something was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_reg <= '0;
        else        ptr_reg <= ptr_next;
    end

endmodule

// File: rtl/banked_multiport_memory.sv
// Multi-port RAM split into banks, each with its own read and write round-robin
// arbiter; reads return after a fixed DATA_LAT-cycle per-port pipeline.
module banked_multiport_memory
    import banked_multiport_memory_pkg::*;
#(
    parameter int READ_PORTS  = 3,
    parameter int WRITE_PORTS = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_BANKS   = 2,
    parameter int DATA_LAT    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] r_addr,
    input  logic [READ_PORTS-1:0]                 r_avalid,
    output logic [READ_PORTS-1:0]                 r_aready,
    output logic [READ_PORTS-1:0]                 r_dvalid,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] r_data,
    input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] w_addr,
    input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] w_data,
    input  logic [WRITE_PORTS-1:0]                w_valid,
    output logic [WRITE_PORTS-1:0]                w_ready
);
    localparam int BK_W   = bank_w_of(NUM_BANKS);
    localparam int RW_W   = ADDR_WIDTH - BK_W;
    localparam int ROW_IW = (RW_W > 0) ? RW_W : 1;
    localparam int ROWS   = 1 << RW_W;
    localparam int BSEL_W = (BK_W > 0) ? BK_W : 1;

    logic [NUM_BANKS-1:0][READ_PORTS-1:0]  r_req;
    logic [NUM_BANKS-1:0][READ_PORTS-1:0]  r_gnt;
    logic [NUM_BANKS-1:0][WRITE_PORTS-1:0] w_req;
    logic [NUM_BANKS-1:0][WRITE_PORTS-1:0] w_gnt;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  bank_rdata;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            for (gj = 0; gj < READ_PORTS; gj++) begin : g_rreq
                assign r_req[gi][gj] = r_avalid[gj] && (int'(bank_of(32'(r_addr[gj]), BK_W)) == gi);
            end
            for (gj = 0; gj < WRITE_PORTS; gj++) begin : g_wreq
                assign w_req[gi][gj] = w_valid[gj] && (int'(bank_of(32'(w_addr[gj]), BK_W)) == gi);
            end

            rr_arbiter #(.N(READ_PORTS)) u_rd_arb (
                .clk   (clk),
                .rst_n (rst_n),
                .req   (r_req[gi]),
                .grant (r_gnt[gi])
            );

            rr_arbiter #(.N(WRITE_PORTS)) u_wr_arb (
                .clk   (clk),
                .rst_n (rst_n),
                .req   (w_req[gi]),
                .grant (w_gnt[gi])
            );

            logic [ROW_IW-1:0]     rd_row;
            logic [ROW_IW-1:0]     wr_row;
            logic [DATA_WIDTH-1:0] wr_data;
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic [DATA_WIDTH-1:0] mem [ROWS];

            // Route the granted port's row/data onto this bank's single access port.
            always_comb begin
                rd_row  = '0;
                wr_row  = '0;
                wr_data = '0;
                for (int p = 0; p < READ_PORTS; p++)
                    if (r_gnt[gi][p]) rd_row = ROW_IW'(row_of(32'(r_addr[p]), BK_W));
                for (int p = 0; p < WRITE_PORTS; p++)
                    if (w_gnt[gi][p]) begin
                        wr_row  = ROW_IW'(row_of(32'(w_addr[p]), BK_W));
                        wr_data = w_data[p];
                    end
            end

            // Registered read sees the pre-write contents on a same-row collision; storage is not reset.
            always_ff @(posedge clk) begin
                if (|r_gnt[gi]) rdata_reg <= mem[rd_row];
                if (|w_gnt[gi]) mem[wr_row] <= wr_data;
            end

            assign bank_rdata[gi] = rdata_reg;
        end
    endgenerate

    // A port's request only reaches one bank, so OR-ing across banks gives its ready.
    always_comb begin
        r_aready = '0;
        w_ready  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            r_aready = r_aready | r_gnt[b];
            w_ready  = w_ready  | w_gnt[b];
        end
    end

    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : g_rport
            logic [DATA_LAT-1:0]   valid_reg;
            logic [BSEL_W-1:0]     bsel_reg;
            logic [DATA_WIDTH-1:0] stage0_data;

            // Valid shift chain plus the bank the in-flight read was sent to.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= '0;
                    bsel_reg  <= '0;
                end else begin
                    valid_reg[0] <= r_aready[gi];
                    for (int k = 1; k < DATA_LAT; k++) valid_reg[k] <= valid_reg[k-1];
                    if (r_aready[gi]) bsel_reg <= BSEL_W'(bank_of(32'(r_addr[gi]), BK_W));
                end
            end

            // Bank output is only meaningful the cycle after acceptance; zero it otherwise.
            assign stage0_data = valid_reg[0] ? bank_rdata[bsel_reg] : '0;

            if (DATA_LAT == 1) begin : g_lat1
                assign r_data[gi]   = stage0_data;
                assign r_dvalid[gi] = valid_reg[0];
            end else begin : g_latn
                logic [DATA_LAT-1:1][DATA_WIDTH-1:0] data_reg;

                // Remaining latency stages; zero data travels with a low valid.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_reg <= '0;
                    end else begin
                        data_reg[1] <= stage0_data;
                        for (int k = 2; k < DATA_LAT; k++) data_reg[k] <= data_reg[k-1];
                    end
                end

                assign r_data[gi]   = data_reg[DATA_LAT-1];
                assign r_dvalid[gi] = valid_reg[DATA_LAT-1];
            end
        end
    endgenerate

endmodule

// File: tb/tb_banked_multiport_memory.sv
// Self-checking bench for banked_multiport_memory (3R/3W, 32b, 16 words, 2 banks, latency 2).
module tb_banked_multiport_memory;

    localparam int RP  = 3;
    localparam int WP  = 3;
    localparam int LAT = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [RP-1:0][3:0]  r_addr = '0;
    logic [RP-1:0]       r_avalid = '0;
    logic [RP-1:0]       r_aready;
    logic [RP-1:0]       r_dvalid;
    logic [RP-1:0][31:0] r_data;
    logic [WP-1:0][3:0]  w_addr = '0;
    logic [WP-1:0][31:0] w_data = '0;
    logic [WP-1:0]       w_valid = '0;
    logic [WP-1:0]       w_ready;

    banked_multiport_memory #(
        .READ_PORTS(RP), .WRITE_PORTS(WP), .DATA_WIDTH(32),
        .ADDR_WIDTH(4), .NUM_BANKS(2), .DATA_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .r_addr(r_addr), .r_avalid(r_avalid), .r_aready(r_aready),
        .r_dvalid(r_dvalid), .r_data(r_data),
        .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input int port);
        total++;
        $display("FAIL %s: port %0d at cycle %0d", name, port, cyc);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic        known;
        int          due;
    } exp_t;

    exp_t        rq [RP][$];
    logic [31:0] exp_mem [16];
    logic        exp_known [16];

    initial for (int a = 0; a < 16; a++) begin
        exp_mem[a]   = '0;
        exp_known[a] = 1'b0;
    end

    // Away from the active edge: retire due reads, push accepted reads, then apply writes.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RP; i++) rq[i].delete();
        end else begin
            for (int i = 0; i < RP; i++) begin
                if (rq[i].size() > 0 && rq[i][0].due < cyc) begin
                    fail_now("dvalid_missing", i);
                    void'(rq[i].pop_front());
                end
                if (r_dvalid[i]) begin
                    if (rq[i].size() == 0) begin
                        fail_now("stray_dvalid", i);
                    end else begin
                        exp_t e;
                        e = rq[i].pop_front();
                        chk($sformatf("dvalid_cycle_p%0d", i), 64'(cyc), 64'(e.due));
                        if (e.known) chk($sformatf("r_data_p%0d", i), 64'(r_data[i]), 64'(e.data));
                    end
                end else begin
                    chk($sformatf("r_data_idle_p%0d", i), 64'(r_data[i]), 64'd0);
                end
                if (r_avalid[i] && r_aready[i]) begin
                    exp_t n;
                    n.data  = exp_mem[r_addr[i]];
                    n.known = exp_known[r_addr[i]];
                    n.due   = cyc + LAT;
                    rq[i].push_back(n);
                end
            end
            for (int j = 0; j < WP; j++) begin
                if (w_valid[j] && w_ready[j]) begin
                    exp_mem[w_addr[j]]   = w_data[j];
                    exp_known[w_addr[j]] = 1'b1;
                end
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  rv;
        logic [3:0]  ra0, ra1, ra2;
        logic [2:0]  wv;
        logic [3:0]  wa0, wa1, wa2;
        logic [31:0] wd0, wd1, wd2;
        logic [2:0]  exp_rr;
        logic [2:0]  exp_wr;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        r_avalid = '0;
        w_valid  = '0;
    endtask

    initial begin
        int last;
        // idle
        vecs[0] = '{3'b000, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000};
        // write 0xDEADBEEF to addr 5 via w port 1
        vecs[1] = '{3'b000, 0, 0, 0, 3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0, 3'b000, 3'b010};
        // read addr 5 on r port 2 the next cycle
        vecs[2] = '{3'b100, 0, 0, 5, 3'b000, 0, 0, 0, 0, 0, 0, 3'b100, 3'b000};
        // writes to two banks in one cycle: addr 3 = 0x11, addr 2 = 0xA5A5
        vecs[3] = '{3'b000, 0, 0, 0, 3'b011, 3, 2, 0, 32'h11, 32'hA5A5, 0, 3'b000, 3'b011};
        // read addr 3 while writing addr 3 = 0x22 -> old data 0x11
        vecs[4] = '{3'b001, 3, 0, 0, 3'b100, 0, 0, 3, 0, 0, 32'h22, 3'b001, 3'b100};
        // read addr 3 next cycle -> 0x22
        vecs[5] = '{3'b010, 0, 3, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b010, 3'b000};
        // reads to bank 0 and bank 1 in the same cycle
        vecs[6] = '{3'b011, 2, 3, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b011, 3'b000};
        // three writes to bank 0 rotate from the pointer left at port 2
        vecs[7] = '{3'b000, 0, 0, 0, 3'b111, 0, 2, 4, 32'h100, 32'h102, 32'h104, 3'b000, 3'b100};
        vecs[8] = '{3'b000, 0, 0, 0, 3'b111, 0, 2, 4, 32'h100, 32'h102, 32'h104, 3'b000, 3'b001};
        vecs[9] = '{3'b000, 0, 0, 0, 3'b111, 0, 2, 4, 32'h100, 32'h102, 32'h104, 3'b000, 3'b010};

        // reset, with requests asserted to show ready stays low
        r_avalid = 3'b111;
        w_valid  = 3'b111;
        repeat (2) step();
        chk("reset_r_aready", 64'(r_aready), 64'd0);
        chk("reset_w_ready",  64'(w_ready),  64'd0);
        chk("reset_r_dvalid", 64'(r_dvalid), 64'd0);
        chk("reset_r_data",   64'(r_data),   64'd0);
        idle();
        step();
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            step();
            r_avalid  = vecs[k].rv;
            r_addr[0] = vecs[k].ra0; r_addr[1] = vecs[k].ra1; r_addr[2] = vecs[k].ra2;
            w_valid   = vecs[k].wv;
            w_addr[0] = vecs[k].wa0; w_addr[1] = vecs[k].wa1; w_addr[2] = vecs[k].wa2;
            w_data[0] = vecs[k].wd0; w_data[1] = vecs[k].wd1; w_data[2] = vecs[k].wd2;
            #3;
            chk($sformatf("vec%0d_r_aready", k), 64'(r_aready), 64'(vecs[k].exp_rr));
            chk($sformatf("vec%0d_w_ready", k),  64'(w_ready),  64'(vecs[k].exp_wr));
        end
        step();
        idle();
        repeat (4) step();

        // reset while a read is in flight: the read must never produce dvalid
        r_avalid  = 3'b010;
        r_addr[1] = 4'd5;
        #3;
        chk("midreset_accept", 64'(r_aready), 64'b010);
        step();
        idle();
        rst_n = 1'b0;
        r_avalid = 3'b111;
        w_valid  = 3'b111;
        #3;
        chk("midreset_r_aready", 64'(r_aready), 64'd0);
        chk("midreset_w_ready",  64'(w_ready),  64'd0);
        step();
        idle();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            #3;
            chk("midreset_no_dvalid", 64'(r_dvalid), 64'd0);
        end

        // fairness: all read ports on addr 4 (bank 0), pointers fresh from reset
        for (int c = 0; c < 6; c++) begin
            step();
            r_avalid = 3'b111;
            r_addr[0] = 4'd4; r_addr[1] = 4'd4; r_addr[2] = 4'd4;
            #3;
            chk($sformatf("rd_rr_c%0d", c), 64'(r_aready), 64'(3'b001 << (c % 3)));
        end
        step();
        idle();

        // three write ports hold requests to bank 1; new data after each acceptance
        last = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (c == 0) begin
                w_valid   = 3'b111;
                w_addr[0] = 4'd1; w_addr[1] = 4'd3; w_addr[2] = 4'd5;
                w_data[0] = 32'hA000_0000; w_data[1] = 32'hB000_0000; w_data[2] = 32'hC000_0000;
            end else begin
                w_data[last] = w_data[last] + 32'h10;
            end
            #3;
            chk($sformatf("wr_rr_c%0d", c), 64'(w_ready), 64'(3'b001 << (c % 3)));
            for (int j = 0; j < WP; j++) if (w_ready[j]) last = j;
        end
        step();
        idle();

        // read back the three addresses
        for (int a = 1; a <= 5; a += 2) begin
            step();
            r_avalid  = 3'b001;
            r_addr[0] = 4'(a);
            #3;
            chk($sformatf("readback_accept_a%0d", a), 64'(r_aready), 64'b001);
        end
        step();
        idle();
        repeat (5) step();

        chk("scoreboard_drained", 64'(rq[0].size() + rq[1].size() + rq[2].size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    // Hard bound on simulated time.
    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
